// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and constants for the req/ack source controller
package cdc_hs_pkg;

    typedef enum logic [1:0] {IDLE, REQ, ACK} hs_state_t;

    localparam int DEF_TIMEOUT = 1024;

    // Width needed to hold 0..t; a disabled or tiny timeout still gets one bit.
    function automatic int cnt_width(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a four-phase req/ack word transfer
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             x_req,
    output logic [WIDTH-1:0] x_data,
    input  logic             x_ack_async,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam int TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TW-1:0] TLAST = TW'(TMAX);

    hs_state_t     state;
    logic [TW-1:0] tcnt;
    logic          timed_out;
    logic          ack_s;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (x_ack_async),
        .q   (ack_s)
    );

    assign s_ready = (state == IDLE) && !rst;

    // Handshake sequencer: accept in IDLE, hold req until ack or timeout, then wait for ack release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_req      <= 1'b0;
            x_data     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
            tcnt       <= '0;
            timed_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        x_data    <= s_data;
                        x_req     <= 1'b1;
                        tcnt      <= '0;
                        timed_out <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        x_req <= 1'b0;
                        tcnt  <= '0;
                        state <= ACK;
                    end else if (TIMEOUT != 0 && tcnt == TLAST) begin
                        x_req     <= 1'b0;
                        err       <= 1'b1;
                        tcnt      <= '0;
                        timed_out <= 1'b1;
                        state     <= ACK;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ACK: begin
                    if (!ack_s) begin
                        state <= IDLE;
                        if (!timed_out) begin
                            done       <= 1'b1;
                            xfer_count <= xfer_count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed checks of the source-side handshake controller
module tb_cdc_handshake_tx;

    localparam int W  = 8;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          x_req;
    logic [W-1:0]  x_data;
    logic          x_ack_async;
    logic          done;
    logic          err;
    logic [CW-1:0] xfer_count;
    logic [CW-1:0] exp_cnt = '0;
    int            ack_mode = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc;
    int            xr;

    cdc_handshake_tx #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .x_req       (x_req),
        .x_data      (x_data),
        .x_ack_async (x_ack_async),
        .done        (done),
        .err         (err),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    // Destination model: 0 never acks, 1 mirrors req half a cycle later, 2 holds ack high.
    always @(negedge clk) x_ack_async = (ack_mode == 2) || (ack_mode == 1 && x_req);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input logic [W-1:0] d, input int exp_done, output int cycles, output int req_hi);
        int   dn;
        logic held;
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        s_data  = ~d;
        chk("req_up", x_req, 1);
        chk("data_lat", x_data, d);
        chk("busy", s_ready, 0);
        dn = 0;
        held = 1'b1;
        cycles = 1;
        req_hi = 1;
        while (!s_ready && cycles < 60) begin
            tick();
            cycles++;
            dn += int'(done);
            req_hi += int'(x_req);
            if (x_data != d) held = 1'b0;
        end
        chk("idle_back", s_ready, 1);
        chk("done_cnt", dn, exp_done);
        chk("data_held", held, 1);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_req", x_req, 0);
        chk("rst_data", x_data, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", xfer_count, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_out", s_ready, 1);

        ack_mode = 1;
        run_xfer(8'hA5, 1, cyc, xr);
        exp_cnt = exp_cnt + 1'b1;
        chk("single_cnt", xfer_count, exp_cnt);
        chk("single_lat", cyc, 7);
        chk("single_req", xr, 3);

        for (int i = 1; i <= 3; i++) begin
            run_xfer(W'(i), 1, cyc, xr);
            exp_cnt = exp_cnt + 1'b1;
            chk("b2b_gap", cyc >= 6, 1);
            chk("b2b_cnt", xfer_count, exp_cnt);
        end
        chk("b2b_total", xfer_count, 4);

        ack_mode = 0;
        run_xfer(8'h77, 0, cyc, xr);
        chk("to_req_cycles", xr, 8);
        chk("to_lat", cyc, 10);
        chk("to_err", err, 1);
        chk("to_cnt", xfer_count, exp_cnt);

        ack_mode = 1;
        run_xfer(8'h88, 1, cyc, xr);
        exp_cnt = exp_cnt + 1'b1;
        chk("after_to_cnt", xfer_count, 5);
        chk("err_sticky", err, 1);

        ack_mode = 2;
        s_valid = 1'b1;
        s_data = 8'h5A;
        tick();
        s_valid = 1'b0;
        tick();
        chk("mid_req", x_req, 1);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'hE7;
        tick();
        chk("mid_rst_req", x_req, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cnt", xfer_count, 0);
        chk("mid_rst_data", x_data, 0);
        rst = 1'b0;
        s_valid = 1'b0;
        exp_cnt = '0;
        repeat (4) tick();
        chk("mid_no_req", x_req, 0);
        chk("mid_idle", s_ready, 1);
        ack_mode = 0;
        repeat (3) tick();

        ack_mode = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spur_ready", s_ready, 1);
            chk("spur_done", done, 0);
        end
        ack_mode = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("spur_quiet", done | x_req, 0);
        end
        ack_mode = 1;
        run_xfer(8'hC3, 1, cyc, xr);
        exp_cnt = exp_cnt + 1'b1;
        chk("spur_next_cnt", xfer_count, exp_cnt);

        for (int i = 0; i < 16; i++) begin
            run_xfer(W'(8'h10 + i), 1, cyc, xr);
            exp_cnt = exp_cnt + 1'b1;
            chk("wrap_step", xfer_count, exp_cnt);
        end
        chk("wrap_final", xfer_count, 1);
        chk("wrap_err", err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
